// File: rtl/fir_coe_cfg_parser.sv
// Parses one checksummed FIR coefficient packet from a 32-bit valid/ready stream, buffers it, and
// replays a validated set as a gap-free burst followed by a single commit pulse.
module fir_coe_cfg_parser #(
   parameter int          COE_NUM      = 51,
   parameter int          COE_WDTH     = 29,
   parameter int          COE_NUM_HALF = (COE_NUM + 1) / 2,
   parameter logic [15:0] MAGIC        = 16'hF1C0,
   parameter int          LOAD_GAP     = 16
) (
   input  logic                cfg_clk,
   input  logic                cfg_rst_n,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   input  logic [31:0]         s_data_i,
   output logic                coe_vld_o,
   output logic                coe_sop_o,
   output logic [COE_WDTH-1:0] coe_din_o,
   output logic                coe_load_o,
   output logic [31:0]         coe_fir_dec_o,
   output logic                cfg_busy_o,
   output logic                cfg_err_o,
   output logic [1:0]          cfg_err_code_o,
   output logic [15:0]         cfg_done_cnt_o
);

   localparam int CMAX = (COE_NUM_HALF > LOAD_GAP) ? COE_NUM_HALF : LOAD_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int AW   = (COE_NUM_HALF > 1) ? $clog2(COE_NUM_HALF) : 1;
   localparam logic [CW-1:0] N_C   = CW'(COE_NUM_HALF);
   localparam logic [CW-1:0] GAP_C = CW'(LOAD_GAP);
   localparam logic [7:0]    N_B   = 8'(COE_NUM_HALF);

   typedef enum logic [2:0] {IDLE, RX_DEC, RX_COE, RX_CSUM, EMIT, SETTLE, LOAD, GAP} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [31:0]         csum_q, csum_d;
   logic [31:0]         dec_stage_q, dec_stage_d;
   logic                s_ready_q, s_ready_d;
   logic                coe_vld_q, coe_vld_d;
   logic                coe_sop_q, coe_sop_d;
   logic [COE_WDTH-1:0] coe_din_q;
   logic                coe_load_q, coe_load_d;
   logic [31:0]         coe_fir_dec_q, coe_fir_dec_d;
   logic                cfg_busy_q, cfg_busy_d;
   logic                cfg_err_q, cfg_err_d;
   logic [1:0]          cfg_err_code_q, cfg_err_code_d;
   logic [15:0]         cfg_done_cnt_q, cfg_done_cnt_d;
   logic                mem_we, mem_rd;
   logic [AW-1:0]       rd_addr;
   logic                xfer;

   // Not reset: contents are only ever read after a full, checksummed fill.
   logic [COE_WDTH-1:0] coe_mem [COE_NUM_HALF];

   assign xfer = s_valid_i && s_ready_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      csum_d         = csum_q;
      dec_stage_d    = dec_stage_q;
      coe_vld_d      = 1'b0;
      coe_sop_d      = 1'b0;
      coe_load_d     = 1'b0;
      coe_fir_dec_d  = coe_fir_dec_q;
      cfg_err_d      = 1'b0;
      cfg_err_code_d = cfg_err_code_q;
      cfg_done_cnt_d = cfg_done_cnt_q;
      mem_we         = 1'b0;
      mem_rd         = 1'b0;
      rd_addr        = AW'(cnt_q);
      case (state_q)
         IDLE: begin
            csum_d = '0;
            if (xfer) begin
               if (s_data_i[31:16] != MAGIC) begin
                  cfg_err_d      = 1'b1;
                  cfg_err_code_d = 2'd1;
               end else if (s_data_i[15:8] != N_B) begin
                  cfg_err_d      = 1'b1;
                  cfg_err_code_d = 2'd2;
               end else begin
                  state_d = RX_DEC;
                  csum_d  = s_data_i;
                  cnt_d   = '0;
               end
            end
         end
         RX_DEC: begin
            if (xfer) begin
               dec_stage_d = s_data_i;
               csum_d      = csum_q ^ s_data_i;
               cnt_d       = '0;
               state_d     = RX_COE;
            end
         end
         RX_COE: begin
            if (xfer) begin
               mem_we = 1'b1;
               csum_d = csum_q ^ s_data_i;
               if (cnt_q == N_C - 1'b1) begin
                  cnt_d   = '0;
                  state_d = RX_CSUM;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RX_CSUM: begin
            if (xfer) begin
               csum_d = '0;
               if (s_data_i == csum_q) begin
                  state_d       = EMIT;
                  coe_vld_d     = 1'b1;
                  coe_sop_d     = 1'b1;
                  mem_rd        = 1'b1;
                  rd_addr       = '0;
                  cnt_d         = CW'(1);
                  coe_fir_dec_d = dec_stage_q;
               end else begin
                  state_d        = IDLE;
                  cfg_err_d      = 1'b1;
                  cfg_err_code_d = 2'd3;
               end
            end
         end
         EMIT: begin
            // cnt_q is the index of the next coefficient to present.
            if (cnt_q == N_C) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else begin
               coe_vld_d = 1'b1;
               mem_rd    = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(1)) begin
               state_d        = LOAD;
               coe_load_d     = 1'b1;
               cfg_done_cnt_d = cfg_done_cnt_q + 16'd1;
               cnt_d          = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            state_d = GAP;
            cnt_d   = '0;
         end
         GAP: begin
            if (cnt_q == GAP_C - 1'b1) begin
               state_d = IDLE;
               cnt_d   = '0;
               csum_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      s_ready_d  = (state_d == IDLE) || (state_d == RX_DEC) ||
                   (state_d == RX_COE) || (state_d == RX_CSUM);
      cfg_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge cfg_clk) begin
      if (mem_we) coe_mem[AW'(cnt_q)] <= s_data_i[COE_WDTH-1:0];
   end

   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         csum_q         <= '0;
         dec_stage_q    <= '0;
         s_ready_q      <= 1'b0;
         coe_vld_q      <= 1'b0;
         coe_sop_q      <= 1'b0;
         coe_din_q      <= '0;
         coe_load_q     <= 1'b0;
         coe_fir_dec_q  <= '0;
         cfg_busy_q     <= 1'b0;
         cfg_err_q      <= 1'b0;
         cfg_err_code_q <= '0;
         cfg_done_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         csum_q         <= csum_d;
         dec_stage_q    <= dec_stage_d;
         s_ready_q      <= s_ready_d;
         coe_vld_q      <= coe_vld_d;
         coe_sop_q      <= coe_sop_d;
         if (mem_rd) coe_din_q <= coe_mem[rd_addr];
         coe_load_q     <= coe_load_d;
         coe_fir_dec_q  <= coe_fir_dec_d;
         cfg_busy_q     <= cfg_busy_d;
         cfg_err_q      <= cfg_err_d;
         cfg_err_code_q <= cfg_err_code_d;
         cfg_done_cnt_q <= cfg_done_cnt_d;
      end
   end

   assign s_ready_o      = s_ready_q;
   assign coe_vld_o      = coe_vld_q;
   assign coe_sop_o      = coe_sop_q;
   assign coe_din_o      = coe_din_q;
   assign coe_load_o     = coe_load_q;
   assign coe_fir_dec_o  = coe_fir_dec_q;
   assign cfg_busy_o     = cfg_busy_q;
   assign cfg_err_o      = cfg_err_q;
   assign cfg_err_code_o = cfg_err_code_q;
   assign cfg_done_cnt_o = cfg_done_cnt_q;

endmodule
